register_bank: RTL and testbench
================================

// Module: register_bank
// PURPOSE
//  Parametrised multi-register bank for the 4-bit CPU datapath. It succeeds the
//  single-register element with DEPTH registers of WIDTH bits, two combinational
//  read ports and one write port. The write port can load, increment, decrement
//  or accumulate, and the last write op leaves registered carry and zero flags.
//  The ALU/decoder drives the bank; the flags feed conditional-branch logic.
// PARAMETERS
//  WIDTH   4  data bits per register (>=2)
//  DEPTH   4  number of registers (>=2; need not be a power of two)
//  AW      2  address width; must satisfy 2**AW >= DEPTH
//  BYPASS  1  1 = a read of the register being written returns the new result
//             in the same cycle; 0 = the read returns the pre-write value
// PORTS
//  clk_cpu  in   1      CPU clock; all state updates on its rising edge
//  reset    in   1      asynchronous, active-high reset
//  we       in   1      write strobe; the op executes on the clk_cpu edge while high
//  wmode    in   2      00 LOAD, 01 INC, 10 DEC, 11 ADD
//  waddr    in   AW     target register index
//  wdata    in   WIDTH  operand for LOAD/ADD; ignored for INC/DEC
//  raddr_a  in   AW     read port A index
//  raddr_b  in   AW     read port B index
//  rdata_a  out  WIDTH  contents of register raddr_a (combinational)
//  rdata_b  out  WIDTH  contents of register raddr_b (combinational)
//  carry    out  1      carry/borrow of the last executed write op (registered)
//  zero     out  1      1 if the last executed write result was 0 (registered)
// BEHAVIOUR
//  - Reset (async, active-high): all registers, carry and zero clear to 0 at
//    once. While reset is high, writes are ignored. Reset asserted in the same
//    cycle as we=1 wins: no write takes effect.
//  - Result R (WIDTH bits, modulo 2**WIDTH), with cur = reg[waddr]:
//      LOAD R=wdata        C=0
//      INC  R=cur+1        C=carry out of the MSB (cur all ones -> R=0, C=1)
//      DEC  R=cur-1        C=borrow (cur=0 -> R=all ones, C=1)
//      ADD  R=cur+wdata    C=carry out of the MSB
//  - On a clk_cpu edge with we=1 and waddr<DEPTH: reg[waddr]<=R, carry<=C,
//    zero<=(R==0). Latency is one cycle; all three update on the same edge.
//  - we=0: registers and flags hold.
//  - waddr>=DEPTH with we=1: the write is dropped and the flags hold.
//  - Reads: rdata_x = reg[raddr_x]. If raddr_x>=DEPTH, rdata_x=0.
//  - BYPASS=1: if we=1, raddr_x==waddr and waddr<DEPTH, then rdata_x=R
//    combinationally. BYPASS=0: rdata_x is the stored value until the edge.
//  - Both read ports may address the same register, including the write target;
//    both ports return the same value.
//  - Back-to-back ops on one register chain: each op uses the value committed
//    by the previous edge.
// TESTING
//  1 Reset: write 4'hA to r0..r3, pulse reset mid-cycle -> all rdata=0, carry=0,
//    zero=0 immediately, without waiting for a clock edge.
//  2 LOAD/read: load r1=4'h5, r2=4'hC; raddr_a=1, raddr_b=2 -> 5/C; carry=0,
//    zero=0; LOAD 0 to r3 -> zero=1.
//  3 Wrap: r0=4'hF, INC -> r0=0, C=1, Z=1; DEC r0 -> F, C=1, Z=0;
//    ADD r0+4'h2 -> 1, C=1.
//  4 Bypass: BYPASS=1, r2=3, same cycle INC r2 with raddr_a=2 -> rdata_a=4
//    before the edge; BYPASS=0 -> 3 before the edge, 4 after.
//  5 Range: DEPTH=3, write waddr=3 -> no register changes and the flags hold;
//    raddr_b=3 -> rdata_b=0.
//  6 Reset collision: reset and we (LOAD 4'h7 to r1) in the same cycle ->
//    r1 stays 0 after reset releases.

Source files
------------

// File: rtl/register_bank.sv
// rtl/register_bank.sv - parametrised multi-register bank with arithmetic write port and flags
//
// DEPTH registers of WIDTH bits for the 4-bit CPU datapath. One write port
// performs LOAD / INC / DEC / ADD on the addressed register and leaves
// registered carry and zero flags. Two combinational read ports, with an
// optional same-cycle bypass of the write result.
//
// Ports:
//   clk_cpu  in   CPU clock, rising-edge state updates
//   reset    in   asynchronous, active-high reset
//   we       in   write strobe
//   wmode    in   2'b00 LOAD, 2'b01 INC, 2'b10 DEC, 2'b11 ADD
//   waddr    in   write target index
//   wdata    in   operand for LOAD / ADD
//   raddr_a  in   read port A index
//   raddr_b  in   read port B index
//   rdata_a  out  read port A data (combinational)
//   rdata_b  out  read port B data (combinational)
//   carry    out  carry/borrow of the last executed write op
//   zero     out  1 when the last executed write result was 0
module register_bank #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int BYPASS = 1
) (
    input  logic             clk_cpu,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       wmode,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             carry,
    output logic             zero
);

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;

    logic [WIDTH-1:0] regs [DEPTH];

    logic [WIDTH-1:0] cur;
    logic             w_hit;
    logic             wr_en;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;

    // Decode the write target by comparison rather than direct indexing so
    // that a non-power-of-two DEPTH never indexes past the array.
    always_comb begin
        cur   = '0;
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
                cur   = regs[i];
                w_hit = 1'b1;
            end
        end
    end

    assign wr_en = we & w_hit;

    // One extra bit holds the carry; for DEC the subtraction wraps the extra
    // bit to 1 exactly when cur was 0, which is the borrow.
    always_comb begin
        case (wmode)
            MODE_LOAD: sum = {1'b0, wdata};
            MODE_INC:  sum = {1'b0, cur} + (WIDTH+1)'(1);
            MODE_DEC:  sum = {1'b0, cur} - (WIDTH+1)'(1);
            default:   sum = {1'b0, cur} + {1'b0, wdata};
        endcase
    end

    assign res   = sum[WIDTH-1:0];
    assign res_c = sum[WIDTH];

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    regs[i] <= res;
                end
            end
            carry <= res_c;
            zero  <= (res == '0);
        end
    end

    // Out-of-range read addresses fall through to zero.
    always_comb begin
        rdata_a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                rdata_a = regs[i];
            end
        end
        if (BYPASS != 0 && wr_en && !reset && raddr_a == waddr) begin
            rdata_a = res;
        end
    end

    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_b == AW'(i)) begin
                rdata_b = regs[i];
            end
        end
        if (BYPASS != 0 && wr_en && !reset && raddr_b == waddr) begin
            rdata_b = res;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - self-checking bench for register_bank
module tb_register_bank;

    logic       clk_cpu;
    logic       reset;
    logic       we;
    logic [1:0] wmode;
    logic [1:0] waddr;
    logic [3:0] wdata;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;

    logic [3:0] rd_a [3];
    logic [3:0] rd_b [3];
    logic       car  [3];
    logic       zer  [3];

    int tests;
    int failed;

    // Instance 0: defaults (DEPTH 4, bypass). 1: no bypass. 2: DEPTH 3.
    localparam int DEP [3] = '{4, 4, 3};
    localparam int BYP [3] = '{1, 0, 1};

    int mem [3][4];
    int mc  [3];
    int mz  [3];

    register_bank #(.WIDTH(4), .DEPTH(4), .AW(2), .BYPASS(1)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .we(we), .wmode(wmode), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[0]), .rdata_b(rd_b[0]), .carry(car[0]), .zero(zer[0]));

    register_bank #(.WIDTH(4), .DEPTH(4), .AW(2), .BYPASS(0)) dut_nb (
        .clk_cpu(clk_cpu), .reset(reset), .we(we), .wmode(wmode), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[1]), .rdata_b(rd_b[1]), .carry(car[1]), .zero(zer[1]));

    register_bank #(.WIDTH(4), .DEPTH(3), .AW(2), .BYPASS(1)) dut_d3 (
        .clk_cpu(clk_cpu), .reset(reset), .we(we), .wmode(wmode), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[2]), .rdata_b(rd_b[2]), .carry(car[2]), .zero(zer[2]));

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // Reference arithmetic on plain integers: result modulo 16, carry when the
    // true value leaves 0..15.
    function automatic void model_result(input int cur, output int r, output int c);
        int t;
        case (int'(wmode))
            0:       t = int'(wdata);
            1:       t = cur + 1;
            2:       t = cur - 1;
            default: t = cur + int'(wdata);
        endcase
        c = (wmode == 2'b00) ? 0 : ((t < 0 || t > 15) ? 1 : 0);
        r = (t + 16) % 16;
    endfunction

    function automatic int exp_read(input int k, input int ra);
        int r;
        int c;
        if (ra >= DEP[k]) return 0;
        if (BYP[k] != 0 && we && !reset && int'(waddr) < DEP[k] && ra == int'(waddr)) begin
            model_result(mem[k][ra], r, c);
            return r;
        end
        return mem[k][ra];
    endfunction

    task automatic model_commit();
        int r;
        int c;
        for (int k = 0; k < 3; k++) begin
            if (we && int'(waddr) < DEP[k]) begin
                model_result(mem[k][int'(waddr)], r, c);
                mem[k][int'(waddr)] = r;
                mc[k] = c;
                mz[k] = (r == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) mem[k][i] = 0;
            mc[k] = 0;
            mz[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s[inst%0d] observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic chk_reads();
        for (int k = 0; k < 3; k++) begin
            chk("rdata_a", k, {4'h0, rd_a[k]}, 8'(exp_read(k, int'(raddr_a))));
            chk("rdata_b", k, {4'h0, rd_b[k]}, 8'(exp_read(k, int'(raddr_b))));
        end
    endtask

    task automatic chk_flags();
        for (int k = 0; k < 3; k++) begin
            chk("carry", k, {7'h0, car[k]}, 8'(mc[k]));
            chk("zero",  k, {7'h0, zer[k]}, 8'(mz[k]));
        end
    endtask

    // Entered just after a rising edge: drive, check reads (incl. bypass)
    // before the next edge, then check flags just after it.
    task automatic step(input logic w, input logic [1:0] m, input logic [1:0] wa,
                        input logic [3:0] wd, input logic [1:0] ra, input logic [1:0] rb);
        we = w; wmode = m; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        @(negedge clk_cpu);
        chk_reads();
        @(posedge clk_cpu);
        model_commit();
        #1;
        chk_flags();
    endtask

    task automatic chk_all_regs();
        raddr_a = 2'd0; raddr_b = 2'd1; #1; chk_reads();
        raddr_a = 2'd2; raddr_b = 2'd3; #1; chk_reads();
    endtask

    initial begin
        tests = 0;
        failed = 0;
        model_reset();
        reset = 1'b1; we = 1'b0; wmode = 2'b00; waddr = 2'd0; wdata = 4'h0;
        raddr_a = 2'd0; raddr_b = 2'd0;

        // Reset state
        chk_all_regs();
        chk_flags();
        reset = 1'b0;
        @(posedge clk_cpu);
        #1;

        // Fill with A, then 0xA+6 on r3 sets carry and zero
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 2'(i), 4'hA, 2'(i), 2'(3 - i));
        step(1'b1, 2'b11, 2'd3, 4'h6, 2'd3, 2'd0);
        step(1'b0, 2'b00, 2'd0, 4'h0, 2'd0, 2'd2);

        // Mid-cycle reset pulse clears everything without an edge
        we = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all_regs();
        chk_flags();
        reset = 1'b0;
        @(posedge clk_cpu);
        #1;

        // LOAD and read
        step(1'b1, 2'b00, 2'd1, 4'h5, 2'd0, 2'd0);
        step(1'b1, 2'b00, 2'd2, 4'hC, 2'd1, 2'd0);
        step(1'b0, 2'b00, 2'd0, 4'h0, 2'd1, 2'd2);
        step(1'b1, 2'b00, 2'd3, 4'h0, 2'd1, 2'd2);

        // Wrap cases on r0
        step(1'b1, 2'b00, 2'd0, 4'hF, 2'd0, 2'd0);
        step(1'b1, 2'b01, 2'd0, 4'h0, 2'd0, 2'd1);
        step(1'b1, 2'b10, 2'd0, 4'h9, 2'd0, 2'd0);
        step(1'b1, 2'b11, 2'd0, 4'h2, 2'd1, 2'd0);

        // Bypass vs stored read on both ports
        step(1'b1, 2'b00, 2'd2, 4'h3, 2'd0, 2'd1);
        step(1'b1, 2'b01, 2'd2, 4'h0, 2'd2, 2'd2);
        step(1'b0, 2'b01, 2'd2, 4'h0, 2'd2, 2'd3);

        // Out-of-range write/read on the DEPTH=3 instance, flags must hold
        step(1'b1, 2'b00, 2'd1, 4'hF, 2'd1, 2'd0);
        step(1'b1, 2'b01, 2'd1, 4'h0, 2'd1, 2'd3);
        step(1'b1, 2'b00, 2'd3, 4'h5, 2'd3, 2'd3);
        step(1'b0, 2'b00, 2'd0, 4'h0, 2'd0, 2'd3);

        // Reset and a write on the same edge: reset wins
        we = 1'b1; wmode = 2'b00; waddr = 2'd1; wdata = 4'h7;
        reset = 1'b1;
        @(posedge clk_cpu);
        model_reset();
        #1;
        reset = 1'b0;
        we = 1'b0;
        step(1'b0, 2'b00, 2'd0, 4'h0, 2'd1, 2'd1);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 4'($urandom),
                 2'($urandom), 2'($urandom));
        end
        we = 1'b0;
        #1;
        chk_all_regs();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
